// File: rtl/fa_4_1bit.sv
// Registered 4-bit ripple-carry adder: {cout, sum} = a + b + cin, one cycle latency.
// Built from four chained fa_1bit cells; the ripple path is the critical path.

module fa_1bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);

endmodule

module fa_4_1bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;
    logic [3:0] sum_d;
    logic       cout_d;
    logic [3:0] sum_q;
    logic       cout_q;

    assign carry[0] = cin;

    // carry[gi+1] is the carry out of cell gi; no lookahead by design.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cell
            fa_1bit u_cell (
                .x  (a[gi]),
                .y  (b[gi]),
                .ci (carry[gi]),
                .s  (sum_d[gi]),
                .co (carry[gi+1])
            );
        end
    endgenerate

    assign cout_d = carry[4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= 4'b0000;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_fa_4_1bit.sv
// Directed and exhaustive checks of fa_4_1bit with immediate assertions.
// Inputs are driven on the falling edge; outputs are sampled #1 after the rising edge.

module tb_fa_4_1bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;

    int n_cmp;
    int n_mis;

    fa_4_1bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {cout, sum};
        n_cmp++;
        $display("txn %s: a=%b b=%b cin=%b rst_n=%b -> {cout,sum}=%b exp=%b",
                 tag, a, b, cin, rst_n, obs, exp);
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive operands on the falling edge, let one rising edge register them.
    task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        @(negedge clk);
        a   = av;
        b   = bv;
        cin = cv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp_prev;
        n_cmp = 0;
        n_mis = 0;
        a     = 4'b1010;
        b     = 4'b0110;
        cin   = 1'b1;
        rst_n = 1'b0;

        // Reset state with nonzero operands applied.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 5'b00000);

        @(negedge clk);
        rst_n = 1'b1;

        step(4'b0010, 4'b0101, 1'b0); check("basic_add",    5'b0_0111);
        step(4'b0000, 4'b0000, 1'b0); check("zero",         5'b0_0000);
        step(4'b0000, 4'b0000, 1'b1); check("zero_cin",     5'b0_0001);
        step(4'b1001, 4'b0100, 1'b0); check("no_carry",     5'b0_1101);
        step(4'b1111, 4'b1111, 1'b1); check("max",          5'b1_1111);
        step(4'b1111, 4'b0000, 1'b1); check("full_ripple",  5'b1_0000);
        step(4'b0111, 4'b0001, 1'b0); check("ripple_3",     5'b0_1000);
        step(4'b1000, 4'b1000, 1'b0); check("top_carry",    5'b1_0000);

        // Mid-cycle reset glitch must not disturb registered outputs.
        step(4'b1111, 4'b1111, 1'b1);
        #1 rst_n = 1'b0;
        #1 check("async_low_no_effect", 5'b1_1111);
        rst_n = 1'b1;

        // Reset for one edge with max operands held, then release.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mid_stream", 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 5'b1_1111);

        // Exhaustive, back-to-back, checked with a one-cycle lag.
        exp_prev = 5'b0;
        for (int i = 0; i <= 512; i++) begin
            @(negedge clk);
            if (i > 0) check("exhaustive", exp_prev);
            if (i < 512) begin
                a        = i[3:0];
                b        = i[7:4];
                cin      = i[8];
                exp_prev = 5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
